fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one synchronous FIFO write port (wr_en, data_in, full) among NUM_REQ requesters.
- Grants one requester at a time for a burst of up to MAX_BURST words, then rotates to the next requester.
- Sits between producer blocks and the FIFO instance, on the same clock.
- The FIFO read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int                STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request strictly after i_last, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  int w_pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pos = (int'(i_last) + k) % NUM_REQ;
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester word counters via FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [IDX_W-1:0]          owner,
  output logic                      busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,output logic [NUM_REQ*STAT_W-1:0] stat_words
`endif
);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_beat;

  logic               w_found;
  logic [IDX_W-1:0]   w_next;
  logic               w_xfer;
  logic               w_burst_done;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (req),
    .i_last  (r_owner),
    .o_found (w_found),
    .o_idx   (w_next)
  );

  // Write path is purely combinational: the grant already selects exactly one line.
  assign ack          = r_gnt & req & {NUM_REQ{~fifo_full}};
  assign w_xfer       = |ack;
  assign fifo_wr_en   = w_xfer;
  assign fifo_data_in = req_data[int'(r_owner)*DATA_W +: DATA_W];

  assign w_burst_done = req_last[r_owner] || (r_beat == CNT_W'(MAX_BURST - 1));

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = (r_state == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= IDX_W'(NUM_REQ - 1);
      r_beat  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state         <= BURST;
            r_owner         <= w_next;
            r_gnt           <= '0;
            r_gnt[w_next]   <= 1'b1;
            r_beat          <= '0;
          end
        end
        BURST: begin
          if (w_xfer) begin
            if (w_burst_done) begin
              r_state <= IDLE;
              r_gnt   <= '0;
              r_beat  <= '0;
            end else begin
              r_beat  <= r_beat + 1'b1;
            end
          end else if (!req[r_owner]) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_beat  <= '0;
          end
          // Otherwise the FIFO is full: hold grant and beat count indefinitely.
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_beat  <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [STAT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst)
        r_cnt <= '0;
      else if (ack[g] && (r_cnt != STAT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
    assign stat_words[g*STAT_W +: STAT_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_last, gnt, ack;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_wr_en, busy;
  logic [DW-1:0]   fifo_data_in;
  logic [IW-1:0]   owner;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [N*16-1:0] stat_words;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .gnt          (gnt),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .owner        (owner),
    .busy         (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,.stat_words  (stat_words)
`endif
  );

  typedef struct packed { logic [DW-1:0] data; logic last; } word_t;
  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          wr;
    logic          busy;
    logic [IW-1:0] owner;
  } exp_t;

  word_t         pq [N][$];
  exp_t          ctrl_q[$];
  logic [DW-1:0] wr_q[$];
  int checks   = 0;
  int failures = 0;

  // Model: who holds the grant (-1 none), who won last, words in this burst.
  int m_grant = -1;
  int m_owner = N - 1;
  int m_beats = 0;
  int m_stat[N];

  logic         p_rst  = 1'b1;
  logic         p_full = 1'b0;
  logic [N-1:0] p_req  = '0;
  logic [N-1:0] p_last = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic model_update();
    bit xfer;
    xfer = (m_grant >= 0) && p_req[m_grant] && !p_full;
    if (xfer) begin
      void'(pq[m_grant].pop_front());
      if (m_stat[m_grant] < 65535) m_stat[m_grant]++;
    end
    if (p_rst) begin
      m_grant = -1; m_owner = N - 1; m_beats = 0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
    end else if (m_grant < 0) begin
      for (int k = N; k >= 1; k--)
        if (p_req[(m_owner + k) % N]) m_grant = (m_owner + k) % N;
      if (m_grant >= 0) begin m_owner = m_grant; m_beats = 0; end
    end else if (xfer) begin
      m_beats++;
      if (p_last[m_grant] || m_beats == MB) m_grant = -1;
    end else if (!p_req[m_grant]) begin
      m_grant = -1;
    end
  endtask

  // refill: 0 = none, 1 = endless bursts without last, 2 = random last markers
  task automatic tick(input logic r, input logic f, input logic [N-1:0] en, input int refill);
    exp_t  e;
    word_t w;
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < N; i++)
      if (refill != 0 && pq[i].size() < 2) begin
        w.data = DW'($urandom);
        w.last = (refill == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        pq[i].push_back(w);
      end
    rst = r; fifo_full = f;
    for (int i = 0; i < N; i++) begin
      if (en[i] && pq[i].size() > 0) begin
        req[i] = 1'b1; req_data[i*DW +: DW] = pq[i][0].data; req_last[i] = pq[i][0].last;
      end else begin
        req[i] = 1'b0; req_data[i*DW +: DW] = DW'($urandom); req_last[i] = 1'($urandom);
      end
    end
    e = '0;
    e.owner = IW'(m_owner);
    if (m_grant >= 0) begin
      e.gnt[m_grant] = 1'b1;
      e.busy = 1'b1;
      if (req[m_grant] && !f) begin
        e.ack[m_grant] = 1'b1;
        e.wr = 1'b1;
        wr_q.push_back(pq[m_grant][0].data);
      end
    end
    ctrl_q.push_back(e);
    p_rst = r; p_full = f; p_req = req; p_last = req_last;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [DW-1:0] d;
    if (ctrl_q.size() > 0) begin
      e = ctrl_q.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("ack", 32'(ack), 32'(e.ack));
      chk("wr_en", 32'(fifo_wr_en), 32'(e.wr));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("owner", 32'(owner), 32'(e.owner));
      if (e.wr) begin
        d = wr_q.pop_front();
        if (fifo_wr_en) chk("data", 32'(fifo_data_in), 32'(d));
      end
`ifdef FIFO_WR_ARBITER_STATS_EN
      for (int i = 0; i < N; i++)
        chk("stat", 32'(stat_words[i*16 +: 16]), 32'(m_stat[i]));
`endif
    end
  end

  initial begin
    word_t w;
    rst = 1'b1; fifo_full = 1'b0; req = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
    repeat (2) tick(1'b1, 1'b0, 4'b0000, 0);
    repeat (2) tick(1'b0, 1'b0, 4'b0000, 0);
    // single requester, two-word burst AA,55
    w.data = 8'hAA; w.last = 1'b0; pq[0].push_back(w);
    w.data = 8'h55; w.last = 1'b1; pq[0].push_back(w);
    repeat (6) tick(1'b0, 1'b0, 4'b0001, 0);
    // all requesters continuous, full-length bursts, then a 3-cycle full stall
    repeat (22) tick(1'b0, 1'b0, 4'b1111, 1);
    for (int c = 0; c < 16; c++) tick(1'b0, (c >= 6 && c < 9), 4'b1111, 1);
    // reset pulse mid-burst, then only requesters 0/1 asking
    repeat (3) tick(1'b0, 1'b0, 4'b1111, 1);
    tick(1'b1, 1'b0, 4'b1111, 1);
    repeat (8) tick(1'b0, 1'b0, 4'b0011, 1);
    // requester withdrawal with requester 3 pending
    repeat (3) tick(1'b0, 1'b0, 4'b1010, 1);
    repeat (8) tick(1'b0, 1'b0, 4'b1000, 1);
    // randomized traffic
    for (int c = 0; c < 3000; c++)
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
           4'($urandom), 2);
    repeat (4) tick(1'b0, 1'b0, 4'b0000, 0);
    @(negedge clk);
    #1;
    chk("drain", 32'(ctrl_q.size() + wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
